uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter between NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one UART TX serializer
// among NUM_REQ byte-stream requesters. An owner keeps the serializer until
// it sends a byte flagged last, or until it stalls past HOLD_TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned HOLD_TIMEOUT = 2700
) (
    input  logic                   clock,
    input  logic                   n_reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   tx_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [2:0]             grant_id,
    output logic                   grant_valid,
    output logic                   timeout_evt
);
    localparam int unsigned ID_W   = 3;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_WAIT_TX = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic                gv_q, gv_d;
    logic                last_q, last_d;
    logic                first_q, first_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tmo_q, tmo_d;

    logic                sel_valid;
    logic                sel_last;
    logic [BYTE_W-1:0]   sel_data;
    logic [NUM_REQ-1:0]  sel_onehot;
    logic [2*NUM_REQ-1:0] valid_rot;
    logic                pick_found;
    logic [ID_W-1:0]     pick_id;
    logic [ID_W-1:0]     rr_next;
    logic                send_fire;

    // Reduce an index in 0..2*NUM_REQ-2 to 0..NUM_REQ-1.
    function automatic logic [ID_W-1:0] wrap_id(input int unsigned v);
        return (v >= NUM_REQ) ? ID_W'(v - NUM_REQ) : ID_W'(v);
    endfunction

    // View of the currently granted requester's inputs.
    always_comb begin
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_data   = '0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_valid     = req_valid[i];
                sel_last      = req_last[i];
                sel_data      = req_data[BYTE_W*i +: BYTE_W];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Round-robin pick: first valid requester at or above rr pointer, with wrap.
    always_comb begin
        valid_rot  = {req_valid, req_valid} >> rr_q;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && valid_rot[k]) begin
                pick_found = 1'b1;
                pick_id    = wrap_id(32'(rr_q) + k);
            end
        end
    end

    assign rr_next   = wrap_id(32'(grant_q) + 32'd1);
    assign send_fire = (state_q == S_SEND) && tx_ready && sel_valid;

    // State and datapath registers.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            gv_q    <= 1'b0;
            last_q  <= 1'b0;
            first_q <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            gv_q    <= gv_d;
            last_q  <= last_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state and lock bookkeeping.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        gv_d    = gv_q;
        last_d  = last_q;
        first_d = 1'b0;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_id;
                    gv_d    = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (send_fire) begin
                    last_d  = sel_last;
                    first_d = 1'b1;
                    state_d = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                // The serializer still shows ready in the cycle right after a
                // load, so that first cycle is skipped.
                if (!first_q && tx_ready) begin
                    if (last_q) begin
                        gv_d    = 1'b0;
                        rr_d    = rr_next;
                        state_d = S_IDLE;
                    end else if (sel_valid) begin
                        state_d = S_SEND;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (sel_valid) begin
                    state_d = S_SEND;
                end else if (cnt_q == HOLD_LIMIT) begin
                    tmo_d   = 1'b1;
                    gv_d    = 1'b0;
                    rr_d    = rr_next;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte hand-off decoded from registered state and the live handshake inputs.
    always_comb begin
        tx_start  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (send_fire) begin
            tx_start  = 1'b1;
            tx_data   = sel_data;
            req_ready = sel_onehot;
        end
    end

    assign grant_id    = grant_q;
    assign grant_valid = gv_q;
    assign timeout_evt = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester byte queues, a
// serializer model and a scoreboard of expected (owner, byte) hand-offs.
module tb_uart_tx_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned HOLD = 8;
    localparam int unsigned MAXB = 8;

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] data;
    } exp_t;

    logic              clock = 1'b0;
    logic              n_reset = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [2:0]        grant_id;
    logic              grant_valid;
    logic              timeout_evt;

    int errors = 0;
    int checks = 0;
    int ser_busy = 0;
    int ser_cycles = 3;

    exp_t       exp_q[$];
    logic [7:0] src_data [NREQ][MAXB];
    logic       src_last [NREQ][MAXB];
    int         src_len  [NREQ];
    int         src_idx  [NREQ];
    int         src_delay[NREQ];

    logic            s_start, s_gv, s_tmo;
    logic [NREQ-1:0] s_ready;
    logic [7:0]      s_data;
    logic [2:0]      s_gid;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .HOLD_TIMEOUT(HOLD)) dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_ready    (tx_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout_evt (timeout_evt)
    );

    always #5 clock = ~clock;

    // Serializer model: busy for ser_cycles cycles after each load.
    always @(posedge clock) begin
        if (tx_start) ser_busy <= ser_cycles;
        else if (ser_busy != 0) ser_busy <= ser_busy - 1;
    end
    assign tx_ready = (ser_busy == 0);

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            logic v;
            v = (src_delay[i] == 0) && (src_idx[i] < src_len[i]);
            req_valid[i]       = v;
            req_last[i]        = v ? src_last[i][src_idx[i]] : 1'b0;
            req_data[8*i +: 8] = v ? src_data[i][src_idx[i]] : 8'h00;
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NREQ; i++) begin
            src_len[i] = 0; src_idx[i] = 0; src_delay[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic add_byte(input int r, input logic [7:0] d, input logic l);
        src_data[r][src_len[r]] = d;
        src_last[r][src_len[r]] = l;
        src_len[r]++;
    endtask

    task automatic push_exp(input int r, input logic [7:0] d);
        exp_t e;
        e.id = 3'(r);
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One cycle: sample outputs mid-cycle, then advance requester queues after the edge.
    task automatic tick();
        @(negedge clock);
        s_start = tx_start; s_ready = req_ready; s_data = tx_data;
        s_gv = grant_valid; s_gid = grant_id; s_tmo = timeout_evt;
        @(posedge clock);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (s_ready[i] && src_idx[i] < src_len[i]) src_idx[i]++;
            if (src_delay[i] != 0) src_delay[i]--;
        end
        drive();
    endtask

    task automatic test_reset();
        int first_start;
        exp_t e;
        logic [NREQ-1:0] oh;
        first_start = -1;
        clear_src();
        ser_cycles = 3;
        for (int r = 0; r < NREQ; r++) begin
            add_byte(r, 8'hA0 + 8'(r), 1'b1);
            push_exp(r, 8'hA0 + 8'(r));
        end
        n_reset = 1'b0;
        drive();
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_grant_valid: got %b want 0", grant_valid); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        checks++; if (timeout_evt !== 1'b0) begin errors++; $display("FAIL reset_timeout_evt: got %b want 0", timeout_evt); end
        @(posedge clock);
        #1;
        n_reset = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (s_start) begin
                if (first_start < 0) first_start = c + 1;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL reset_order: unexpected start id=%0d data=%02h", s_gid, s_data);
                end else begin
                    e = exp_q.pop_front(); oh = '0; oh[e.id[1:0]] = 1'b1;
                    if (s_gid !== e.id || s_data !== e.data || s_ready !== oh) begin
                        errors++;
                        $display("FAIL reset_order: got id=%0d data=%02h ready=%b want id=%0d data=%02h ready=%b",
                                 s_gid, s_data, s_ready, e.id, e.data, oh);
                    end
                end
            end
            if (exp_q.size() == 0 && !s_gv) break;
        end
        checks++; if (first_start < 1 || first_start > 2) begin errors++; $display("FAIL reset_first_start: got %0d cycles want 1..2", first_start); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reset_drain: %0d bytes pending want 0", exp_q.size()); end
    endtask

    task automatic test_single_packet();
        int pulses, third_c, fall_c, starts;
        exp_t e;
        pulses = 0; third_c = -1; fall_c = -1; starts = 0;
        clear_src();
        ser_cycles = 10;
        add_byte(2, 8'h41, 1'b0); push_exp(2, 8'h41);
        add_byte(2, 8'h42, 1'b0); push_exp(2, 8'h42);
        add_byte(2, 8'h43, 1'b1); push_exp(2, 8'h43);
        drive();
        for (int c = 0; c < 300; c++) begin
            tick();
            if (s_ready[2]) pulses++;
            if (s_start) begin
                starts++;
                if (starts == 3) third_c = c;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL single_data: unexpected start data=%02h", s_data);
                end else begin
                    e = exp_q.pop_front();
                    if (s_data !== e.data || s_gid !== e.id) begin
                        errors++; $display("FAIL single_data: got id=%0d data=%02h want id=%0d data=%02h", s_gid, s_data, e.id, e.data);
                    end
                end
            end
            if (third_c >= 0 && fall_c < 0 && !s_gv) begin fall_c = c; break; end
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL single_ready_pulses: got %0d want 3", pulses); end
        checks++; if (fall_c - third_c != ser_cycles + 2) begin errors++; $display("FAIL single_gv_fall: got %0d cycles want %0d", fall_c - third_c, ser_cycles + 2); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_drain: %0d bytes pending want 0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic [NREQ-1:0] oh;
        clear_src();
        ser_cycles = 3;
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < NREQ; r++) begin
                add_byte(r, 8'(16 * r + p), 1'b1);
                push_exp(r, 8'(16 * r + p));
            end
        end
        drive();
        for (int c = 0; c < 400; c++) begin
            tick();
            checks++;
            if (s_start) begin
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rr_order: unexpected start id=%0d", s_gid);
                end else begin
                    e = exp_q.pop_front(); oh = '0; oh[e.id[1:0]] = 1'b1;
                    if (s_gid !== e.id || s_data !== e.data || s_ready !== oh) begin
                        errors++;
                        $display("FAIL rr_order: got id=%0d data=%02h ready=%b want id=%0d data=%02h ready=%b",
                                 s_gid, s_data, s_ready, e.id, e.data, oh);
                    end
                end
            end else if (s_ready !== '0) begin
                errors++; $display("FAIL rr_stray_ready: got %b want 0000", s_ready);
            end
            if (exp_q.size() == 0 && !s_gv) break;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rr_drain: %0d grants pending want 0", exp_q.size()); end
    endtask

    task automatic test_lock();
        exp_t e;
        logic [NREQ-1:0] oh;
        clear_src();
        ser_cycles = 4;
        add_byte(1, 8'h10, 1'b0); push_exp(1, 8'h10);
        add_byte(1, 8'h11, 1'b1); push_exp(1, 8'h11);
        add_byte(0, 8'h20, 1'b1); push_exp(0, 8'h20);
        src_delay[0] = 2;
        drive();
        for (int c = 0; c < 300; c++) begin
            tick();
            checks++;
            if (s_start) begin
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL lock_order: unexpected start id=%0d", s_gid);
                end else begin
                    e = exp_q.pop_front(); oh = '0; oh[e.id[1:0]] = 1'b1;
                    if (s_gid !== e.id || s_data !== e.data || s_ready !== oh) begin
                        errors++;
                        $display("FAIL lock_order: got id=%0d data=%02h ready=%b want id=%0d data=%02h ready=%b",
                                 s_gid, s_data, s_ready, e.id, e.data, oh);
                    end
                end
            end else if (s_ready !== '0) begin
                errors++; $display("FAIL lock_stray_ready: got %b want 0000", s_ready);
            end
            if (exp_q.size() == 0 && !s_gv) break;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL lock_drain: %0d bytes pending want 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int start_c, tmo_c, tmo_n;
        logic gv_at_tmo;
        exp_t e;
        start_c = -1; tmo_c = -1; tmo_n = 0; gv_at_tmo = 1'b1;
        clear_src();
        ser_cycles = 3;
        add_byte(3, 8'h5A, 1'b0); push_exp(3, 8'h5A);
        add_byte(0, 8'h21, 1'b1); push_exp(0, 8'h21);
        drive();
        for (int c = 0; c < 300; c++) begin
            tick();
            if (s_tmo) begin
                tmo_n++;
                if (tmo_c < 0) begin tmo_c = c; gv_at_tmo = s_gv; end
            end
            if (s_start) begin
                if (start_c < 0) start_c = c;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL timeout_order: unexpected start id=%0d", s_gid);
                end else begin
                    e = exp_q.pop_front();
                    if (s_gid !== e.id || s_data !== e.data) begin
                        errors++; $display("FAIL timeout_order: got id=%0d data=%02h want id=%0d data=%02h", s_gid, s_data, e.id, e.data);
                    end
                end
            end
            if (exp_q.size() == 0 && !s_gv) break;
        end
        checks++; if (tmo_n != 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", tmo_n); end
        checks++;
        if (tmo_c - start_c != ser_cycles + 2 + HOLD) begin
            errors++; $display("FAIL timeout_delay: got %0d cycles after start want %0d", tmo_c - start_c, ser_cycles + 2 + HOLD);
        end
        checks++; if (gv_at_tmo !== 1'b0) begin errors++; $display("FAIL timeout_gv: got %b want 0", gv_at_tmo); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_drain: %0d bytes pending want 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        int seen;
        exp_t e;
        seen = 0;
        clear_src();
        ser_cycles = 5;
        add_byte(2, 8'h30, 1'b0);
        add_byte(2, 8'h31, 1'b1);
        drive();
        for (int c = 0; c < 50; c++) begin
            tick();
            if (s_start) begin seen = 1; break; end
        end
        checks++; if (seen == 0 || s_gid !== 3'd2 || s_data !== 8'h30) begin
            errors++; $display("FAIL areset_first: seen=%0d id=%0d data=%02h want id=2 data=30", seen, s_gid, s_data);
        end
        #2;
        n_reset = 1'b0;
        #1;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL areset_gv: got %b want 0", grant_valid); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL areset_gid: got %0d want 0", grant_id); end
        checks++; if (tx_start !== 1'b0 || req_ready !== '0 || tx_data !== 8'h00) begin
            errors++; $display("FAIL areset_outputs: tx_start=%b req_ready=%b tx_data=%02h want 0", tx_start, req_ready, tx_data);
        end
        clear_src();
        drive();
        @(posedge clock);
        #1;
        n_reset = 1'b1;
        for (int r = 0; r < NREQ; r++) begin
            add_byte(r, 8'hC0 + 8'(r), 1'b1);
            push_exp(r, 8'hC0 + 8'(r));
        end
        drive();
        for (int c = 0; c < 300; c++) begin
            tick();
            if (s_start) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL areset_order: unexpected start id=%0d", s_gid);
                end else begin
                    e = exp_q.pop_front();
                    if (s_gid !== e.id || s_data !== e.data) begin
                        errors++; $display("FAIL areset_order: got id=%0d data=%02h want id=%0d data=%02h", s_gid, s_data, e.id, e.data);
                    end
                end
            end
            if (exp_q.size() == 0 && !s_gv) break;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL areset_drain: %0d grants pending want 0", exp_q.size()); end
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        test_reset();
        test_round_robin();
        test_single_packet();
        test_lock();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
